lcd_row_writer: RTL and testbench
=================================

// Module: lcd_row_writer
// PURPOSE
// Consumer end of the display path. Takes two 16-char ASCII row buffers and writes them to an
// HD44780-compatible 16x2 character LCD over the 8-bit parallel bus. Byte [127:120] of each row is column 0.
// The producer FSM sources the row buffers; this block owns LCD init, timing and refresh sequencing.
// PARAMETERS
// T_PWRUP_CYC  150000  clk cycles of power-up wait after reset release (15 ms @ 10 MHz)
// T_EN_CYC     5       clk cycles lcd_en is held high per byte (>=450 ns)
// T_CMD_CYC    400     clk cycles of wait after lcd_en falls, normal command/data (>=40 us)
// T_CLR_CYC    16000   clk cycles of wait after lcd_en falls, clear-display command (>=1.52 ms)
// PORTS
// clk       in   1    system clock
// nRst      in   1    reset, asynchronous, active-low
// row1      in   128  top-row ASCII, 16 bytes, [127:120] = column 0
// row2      in   128  bottom-row ASCII, same layout
// refresh   in   1    request to redraw both rows; level sampled each cycle
// busy      out  1    high during init or a refresh in progress
// lcd_rs    out  1    0 = command, 1 = data
// lcd_rw    out  1    tied 0 (write only)
// lcd_en    out  1    LCD enable strobe
// lcd_data  out  8    LCD data bus
// BEHAVIOUR
// - Reset: lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, busy=1, pending=0, state PWRUP, counters 0.
// - Byte transaction (lcd_byte_tx): cycle 0 SETUP: rs/data driven, en=0; then T_EN_CYC cycles en=1;
//   then en=0, with rs/data held for T_CMD_CYC cycles (T_CLR_CYC for 8'h01). Duration 1+T_EN+T_wait cycles.
//   The sub-module raises done for 1 cycle on the final wait cycle. data/rs change only in SETUP.
// - States: PWRUP -> INIT -> IDLE -> LINE1 -> ROW1 -> LINE2 -> ROW2 -> IDLE.
//   PWRUP: count T_PWRUP_CYC, then INIT.
//   INIT: commands 8'h38, 8'h0C, 8'h06, 8'h01 in order (rs=0), then IDLE. Init is not skippable.
//   IDLE: busy=0. If refresh or pending is set, snapshot row1/row2 into shadow regs, clear pending,
//     assert busy next cycle, go to LINE1.
//   LINE1: command 8'h80. ROW1: 16 data writes (rs=1), shadow1[127:120] first, 4-bit column counter.
//   LINE2: command 8'hC0. ROW2: 16 data writes from shadow2. At the last done, go to IDLE.
// - Row bytes are sent verbatim (no filtering of non-printables). Inputs are sampled only at snapshot,
//   so mid-refresh changes to row1/row2 do not corrupt the frame.
// - refresh high while busy (INIT or refresh in progress) sets pending (1 deep, coalesced). Exactly one
//   more refresh runs after the current one finishes; a new snapshot is taken at that point.
// - refresh held high continuously: back-to-back refreshes, with 1 IDLE cycle (busy=0) between them.
// - Counter widths: $clog2 of the largest parameter + 1. Counters saturate at the terminal value
//   and never wrap. Column counter wraps 15 -> 0 only on a row transition.
// - Async reset mid-transaction: en drops immediately; sequence restarts at PWRUP with full init.
// - busy rises on the cycle after snapshot and falls on the IDLE entry cycle.
// STRUCTURE
// - lcd_pkg: typedef enum logic [2:0] state_t {PWRUP,INIT,IDLE,LINE1,ROW1,LINE2,ROW2};
//   constants LCD_FUNC_SET=8'h38, LCD_DISP_ON=8'h0C, LCD_ENTRY=8'h06, LCD_CLEAR=8'h01,
//   LCD_LINE1=8'h80, LCD_LINE2=8'hC0.
// - Sub-module lcd_byte_tx: start/rs/byte in; done out; drives lcd_en/lcd_rs/lcd_data; holds the
//   SETUP/EN/WAIT timer. Top level holds sequencing, shadow regs, pending flag and column counter.
// TESTING (overrides T_PWRUP=20, T_EN=2, T_CMD=4, T_CLR=8; bench LCD model decodes en falling edges)
// 1 Reset release, refresh=0 -> en rises after 21 cycles; bytes 38,0C,06,01 with rs=0; busy falls at
//   cycle 20+3*7+11=52; no further en pulses.
// 2 After init, row1="HANGMAN GAME    ", row2="__________      ", 1-cycle refresh -> 34 bytes 80,row1,C0,row2,
//   rs=1 only on row bytes; busy high for 34*7 cycles.
// 3 Change row1 to all 8'h41 during ROW1 -> LCD model still shows the original snapshot.
// 4 Pulse refresh 3 times during one refresh -> exactly one additional frame, carrying latest row values.
// 5 Assert nRst mid-ROW2 with en high -> en=0, data=00, busy=1 at once; after release, full init replays.
// 6 refresh pulsed during INIT -> frame drawn immediately after the 01 clear, with one IDLE cycle between.

Source files
------------

// File: rtl/lcd_row_writer_pkg.sv
// Shared state encoding, LCD command bytes and helpers for the 16x2 row writer.
package lcd_pkg;

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, LINE1, ROW1, LINE2, ROW2} state_t;
  typedef enum logic [1:0] {P_IDLE, P_SETUP, P_EN, P_WAIT} tx_phase_t;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return 32'($clog2(max_val) + 1);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_ENTRY;
      default: return LCD_CLEAR;
    endcase
  endfunction

  // Column 0 lives in bits [127:120].
  function automatic logic [7:0] row_byte(input logic [127:0] row, input logic [3:0] col);
    logic [127:0] shifted;
    shifted = row << {col, 3'b000};
    return shifted[127:120];
  endfunction

endpackage

// File: rtl/lcd_row_writer_byte_tx.sv
// One HD44780 bus write: SETUP cycle, enable pulse, then settle wait; chains
// straight into the next byte when start coincides with the final wait cycle.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int unsigned T_EN_CYC  = 5,
  parameter int unsigned T_CMD_CYC = 400,
  parameter int unsigned T_CLR_CYC = 16000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       start,
  input  logic       tx_rs,
  input  logic [7:0] tx_byte,
  output logic       done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam int unsigned MAX_CYC = (T_CLR_CYC > T_CMD_CYC)
                                  ? ((T_CLR_CYC > T_EN_CYC) ? T_CLR_CYC : T_EN_CYC)
                                  : ((T_CMD_CYC > T_EN_CYC) ? T_CMD_CYC : T_EN_CYC);
  localparam int unsigned CNT_W = cnt_width(MAX_CYC);

  tx_phase_t        phase;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wait_last;
  logic [CNT_W-1:0] wait_sel_c;
  logic             load_c;

  // Only the clear-display command needs the long settle time.
  assign wait_sel_c = (!tx_rs && tx_byte == LCD_CLEAR) ? CNT_W'(T_CLR_CYC - 1)
                                                       : CNT_W'(T_CMD_CYC - 1);
  assign load_c = start && (phase == P_IDLE || (phase == P_WAIT && cnt == wait_last));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      phase     <= P_IDLE;
      cnt       <= '0;
      wait_last <= '0;
      done      <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
    end else begin
      done <= 1'b0;
      if (load_c) begin
        phase     <= P_SETUP;
        cnt       <= '0;
        wait_last <= wait_sel_c;
        lcd_rs    <= tx_rs;
        lcd_data  <= tx_byte;
      end else begin
        case (phase)
          P_SETUP: begin
            phase  <= P_EN;
            lcd_en <= 1'b1;
            cnt    <= '0;
          end
          P_EN: begin
            if (cnt == CNT_W'(T_EN_CYC - 1)) begin
              phase  <= P_WAIT;
              lcd_en <= 1'b0;
              cnt    <= '0;
              done   <= (wait_last == '0);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          P_WAIT: begin
            if (cnt != wait_last) begin
              cnt  <= cnt + CNT_W'(1);
              done <= (cnt + CNT_W'(1) == wait_last);
            end else begin
              phase <= P_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/lcd_row_writer.sv
// Drives a 16x2 HD44780 LCD: power-up wait, init commands, then full two-row
// redraws from snapshotted row buffers on refresh requests.
module lcd_row_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP_CYC = 150000,
  parameter int unsigned T_EN_CYC    = 5,
  parameter int unsigned T_CMD_CYC   = 400,
  parameter int unsigned T_CLR_CYC   = 16000
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic [127:0] row1,
  input  logic [127:0] row2,
  input  logic         refresh,
  output logic         busy,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic [7:0]   lcd_data
);

  localparam int unsigned PWR_W = cnt_width(T_PWRUP_CYC);

  state_t             state;
  logic [PWR_W-1:0]   pwr_cnt;
  logic [1:0]         init_idx;
  logic [3:0]         col;
  logic               pending;
  logic [127:0]       shadow1;
  logic [127:0]       shadow2;
  logic               done;
  logic               pwr_last_c;
  logic               start_c;
  logic               tx_rs_c;
  logic [7:0]         tx_byte_c;

  assign lcd_rw     = 1'b0;
  assign pwr_last_c = (pwr_cnt == PWR_W'(T_PWRUP_CYC - 1));

  // Next byte to launch; issued on a done so writes run with no gap.
  always_comb begin
    start_c   = 1'b0;
    tx_rs_c   = 1'b0;
    tx_byte_c = LCD_FUNC_SET;
    case (state)
      PWRUP: start_c = pwr_last_c;
      INIT: begin
        start_c   = done && (init_idx != 2'd3);
        tx_byte_c = init_cmd(init_idx + 2'd1);
      end
      IDLE: begin
        start_c   = refresh || pending;
        tx_byte_c = LCD_LINE1;
      end
      LINE1: begin
        start_c   = done;
        tx_rs_c   = 1'b1;
        tx_byte_c = row_byte(shadow1, 4'd0);
      end
      ROW1: begin
        start_c = done;
        if (col == 4'd15) begin
          tx_byte_c = LCD_LINE2;
        end else begin
          tx_rs_c   = 1'b1;
          tx_byte_c = row_byte(shadow1, col + 4'd1);
        end
      end
      LINE2: begin
        start_c   = done;
        tx_rs_c   = 1'b1;
        tx_byte_c = row_byte(shadow2, 4'd0);
      end
      ROW2: begin
        start_c   = done && (col != 4'd15);
        tx_rs_c   = 1'b1;
        tx_byte_c = row_byte(shadow2, col + 4'd1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= PWRUP;
      pwr_cnt  <= '0;
      init_idx <= 2'd0;
      col      <= 4'd0;
      pending  <= 1'b0;
      busy     <= 1'b1;
      shadow1  <= '0;
      shadow2  <= '0;
    end else begin
      // A request arriving while busy is remembered once and served afterwards.
      if (state != IDLE && refresh) pending <= 1'b1;
      case (state)
        PWRUP: begin
          if (pwr_last_c) state <= INIT;
          else            pwr_cnt <= pwr_cnt + PWR_W'(1);
        end
        INIT: begin
          if (done) begin
            if (init_idx == 2'd3) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              init_idx <= init_idx + 2'd1;
            end
          end
        end
        IDLE: begin
          if (refresh || pending) begin
            shadow1 <= row1;
            shadow2 <= row2;
            pending <= 1'b0;
            busy    <= 1'b1;
            state   <= LINE1;
          end
        end
        LINE1: begin
          if (done) begin
            state <= ROW1;
            col   <= 4'd0;
          end
        end
        ROW1: begin
          if (done) begin
            if (col == 4'd15) begin
              state <= LINE2;
              col   <= 4'd0;
            end else begin
              col <= col + 4'd1;
            end
          end
        end
        LINE2: begin
          if (done) begin
            state <= ROW2;
            col   <= 4'd0;
          end
        end
        ROW2: begin
          if (done) begin
            if (col == 4'd15) begin
              state <= IDLE;
              busy  <= 1'b0;
              col   <= 4'd0;
            end else begin
              col <= col + 4'd1;
            end
          end
        end
        default: state <= PWRUP;
      endcase
    end
  end

  lcd_byte_tx #(
    .T_EN_CYC  (T_EN_CYC),
    .T_CMD_CYC (T_CMD_CYC),
    .T_CLR_CYC (T_CLR_CYC)
  ) u_tx (
    .clk      (clk),
    .nRst     (nRst),
    .start    (start_c),
    .tx_rs    (tx_rs_c),
    .tx_byte  (tx_byte_c),
    .done     (done),
    .lcd_en   (lcd_en),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data)
  );

endmodule

// File: tb/tb_lcd_row_writer.sv
// Bench for lcd_row_writer: LCD model latches {rs,data} on en falling edges and
// checks them against an expected-byte queue filled as stimulus is applied.
`timescale 1ns/1ps
module tb_lcd_row_writer;

  localparam int unsigned T_PWRUP  = 20;
  localparam int unsigned T_EN     = 2;
  localparam int unsigned T_CMD    = 4;
  localparam int unsigned T_CLR    = 8;
  localparam int          BYTE_CYC = 1 + T_EN + T_CMD;
  localparam int          FRAME_CYC = 34 * BYTE_CYC;

  logic         clk = 1'b0;
  logic         nRst = 1'b0;
  logic         refresh = 1'b0;
  logic [127:0] row1 = '0;
  logic [127:0] row2 = '0;
  logic         busy;
  logic         lcd_rs;
  logic         lcd_rw;
  logic         lcd_en;
  logic [7:0]   lcd_data;

  int         vectors = 0;
  int         miscompares = 0;
  int         rx_count = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  lcd_row_writer #(
    .T_PWRUP_CYC (T_PWRUP),
    .T_EN_CYC    (T_EN),
    .T_CMD_CYC   (T_CMD),
    .T_CLR_CYC   (T_CLR)
  ) dut (
    .clk      (clk),
    .nRst     (nRst),
    .row1     (row1),
    .row2     (row2),
    .refresh  (refresh),
    .busy     (busy),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data)
  );

  always #5 clk = ~clk;

  // LCD model: a write is latched when en falls outside reset.
  always @(negedge lcd_en) begin
    if (nRst === 1'b1) begin
      rx_count++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL lcd_byte: got rs=%0b data=%02h, required no write", lcd_rs, lcd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({lcd_rs, lcd_data} !== mon_exp) begin
          miscompares++;
          $display("FAIL lcd_byte: got rs=%0b data=%02h, required rs=%0b data=%02h",
                   lcd_rs, lcd_data, mon_exp[8], mon_exp[7:0]);
        end
      end
    end
  end

  function automatic logic [127:0] mk_row(input logic [7:0] base);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = base + 8'(i);
    return r;
  endfunction

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
  endtask

  task automatic push_frame(input logic [127:0] r1, input logic [127:0] r2, input int nbytes);
    logic [8:0] f[$];
    f.push_back(9'h080);
    for (int i = 0; i < 16; i++) f.push_back({1'b1, r1[127-8*i -: 8]});
    f.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) f.push_back({1'b1, r2[127-8*i -: 8]});
    for (int i = 0; i < nbytes && i < 34; i++) exp_q.push_back(f[i]);
  endtask

  task automatic pulse_refresh();
    @(negedge clk); refresh = 1'b1;
    @(negedge clk); refresh = 1'b0;
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    refresh = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({lcd_en, lcd_rs, lcd_rw, lcd_data} !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_bus: got en=%0b rs=%0b rw=%0b data=%02h, required all 0",
               lcd_en, lcd_rs, lcd_rw, lcd_data);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_busy: got %0b, required 1", busy);
    end
  endtask

  // Releases reset (must be held low on entry) and checks the init sequence.
  task automatic test_init();
    int en_at, busy_at, rx0;
    en_at = -1;
    busy_at = -1;
    push_init();
    @(negedge clk); nRst = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (lcd_en === 1'b1 && en_at < 0) en_at = n;
      if (busy === 1'b0) begin
        busy_at = n;
        break;
      end
    end
    vectors++;
    if (en_at != T_PWRUP + 1) begin
      miscompares++;
      $display("FAIL init_en_rise: got cycle %0d, required %0d", en_at, T_PWRUP + 1);
    end
    vectors++;
    if (busy_at != 52) begin
      miscompares++;
      $display("FAIL init_busy_fall: got cycle %0d, required 52", busy_at);
    end
    rx0 = rx_count;
    repeat (40) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL init_bytes: got %0d bytes outstanding, required 0", exp_q.size());
    end
    vectors++;
    if (rx_count != rx0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL init_quiet: got %0d extra writes busy=%0b, required 0 writes busy=0",
               rx_count - rx0, busy);
    end
  endtask

  task automatic test_frame();
    int n;
    row1 = "HANGMAN GAME    ";
    row2 = "__________      ";
    push_frame(row1, row2, 34);
    pulse_refresh();
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n != FRAME_CYC) begin
      miscompares++;
      $display("FAIL frame_busy_len: got %0d cycles, required %0d", n, FRAME_CYC);
    end
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL frame_bytes: got %0d bytes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_snapshot();
    int n;
    row1 = mk_row(8'h61);
    row2 = mk_row(8'h30);
    push_frame(row1, row2, 34);
    pulse_refresh();
    repeat (3 * BYTE_CYC) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || lcd_rs !== 1'b1) begin
      miscompares++;
      $display("FAIL snap_in_row1: got busy=%0b rs=%0b, required 1 1", busy, lcd_rs);
    end
    row1 = {16{8'h41}};
    row2 = {16{8'h42}};
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL snap_bytes: got %0d bytes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_coalesce();
    int n, gap;
    row1 = mk_row(8'h41);
    row2 = mk_row(8'h51);
    push_frame(row1, row2, 34);
    pulse_refresh();
    repeat (20) @(negedge clk);
    row1 = mk_row(8'h20); row2 = mk_row(8'h21);
    pulse_refresh();
    repeat (60) @(negedge clk);
    row1 = mk_row(8'h22); row2 = mk_row(8'h23);
    pulse_refresh();
    repeat (60) @(negedge clk);
    row1 = mk_row(8'h61); row2 = mk_row(8'h71);
    push_frame(row1, row2, 34);
    pulse_refresh();
    n = 0;
    while (busy === 1'b1 && n < 2000) begin n++; @(negedge clk); end
    gap = 0;
    while (busy === 1'b0 && gap < 20) begin gap++; @(negedge clk); end
    vectors++;
    if (gap != 1) begin
      miscompares++;
      $display("FAIL coalesce_gap: got %0d idle cycles, required 1", gap);
    end
    n = 0;
    while (busy === 1'b1 && n < 2000) begin n++; @(negedge clk); end
    vectors++;
    if (n != FRAME_CYC) begin
      miscompares++;
      $display("FAIL coalesce_frame_len: got %0d cycles, required %0d", n, FRAME_CYC);
    end
    repeat (30) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL coalesce_single: got %0d outstanding busy=%0b, required 0 busy=0",
               exp_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    row1 = mk_row(8'h61);
    row2 = mk_row(8'h30);
    push_frame(row1, row2, 20);
    pulse_refresh();
    repeat (141) @(negedge clk);
    vectors++;
    if ({lcd_en, lcd_rs, lcd_data} !== {2'b11, 8'h32}) begin
      miscompares++;
      $display("FAIL mid_row2_pre: got en=%0b rs=%0b data=%02h, required 1 1 32",
               lcd_en, lcd_rs, lcd_data);
    end
    #1 nRst = 1'b0;
    #1;
    vectors++;
    if ({busy, lcd_en, lcd_data} !== {2'b10, 8'h00}) begin
      miscompares++;
      $display("FAIL mid_reset_async: got busy=%0b en=%0b data=%02h, required 1 0 00",
               busy, lcd_en, lcd_data);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mid_partial: got %0d bytes outstanding, required 0", exp_q.size());
    end
    test_init();
  endtask

  task automatic test_init_refresh();
    int n, busy_at;
    busy_at = -1;
    nRst = 1'b0;
    repeat (2) @(negedge clk);
    push_init();
    row1 = mk_row(8'h41);
    row2 = mk_row(8'h4E);
    push_frame(row1, row2, 34);
    @(negedge clk); nRst = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 30) refresh = 1'b1;
      if (k == 31) refresh = 1'b0;
      if (busy === 1'b0) begin
        busy_at = k;
        break;
      end
    end
    vectors++;
    if (busy_at != 52) begin
      miscompares++;
      $display("FAIL initref_idle: got cycle %0d, required 52", busy_at);
    end
    @(negedge clk);
    vectors++;
    if ({busy, lcd_en, lcd_rs, lcd_data} !== {3'b100, 8'h80}) begin
      miscompares++;
      $display("FAIL initref_start: got busy=%0b en=%0b rs=%0b data=%02h, required 1 0 0 80",
               busy, lcd_en, lcd_rs, lcd_data);
    end
    n = 0;
    while (busy === 1'b1 && n < 2000) begin n++; @(negedge clk); end
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL initref_bytes: got %0d bytes outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_frame();
    test_snapshot();
    test_coalesce();
    test_reset_mid();
    test_init_refresh();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
